// File: rtl/gb_frame_sequencer.sv
// gb_frame_sequencer
//   Generates the APU frame-sequencer timing strobes. A prescaler divides clk
//   down to the 512 Hz step rate. Each step (tick) registers one-cycle strobes
//   from an 8-entry schedule for the length, sweep and envelope units.
//
// Ports
//   clk            system clock, rising-edge active
//   reset          asynchronous active-low reset
//   apu_enable     APU power; low holds the block cleared and silent
//   div_reset      one-cycle pulse on a DIV write; restarts the prescaler
//   clk_length_ctr one-cycle length-counter strobe (256 Hz)
//   clk_sweep      one-cycle channel-1 sweep strobe (128 Hz)
//   clk_envelope   one-cycle volume-envelope strobe (64 Hz)
//   step           index of the next step to execute
//   length_next    high when the next executed step clocks length
//
// step | strobes raised when the step executes
// -----+---------------------------------------
//  0   | length
//  1   | none
//  2   | length + sweep
//  3   | none
//  4   | length
//  5   | none
//  6   | length + sweep
//  7   | envelope
module gb_frame_sequencer #(
  parameter int CLK_DIV = 8192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       div_reset,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] step,
  output logic       length_next
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_0 = 3'd0, ST_1 = 3'd1, ST_2 = 3'd2, ST_3 = 3'd3,
    ST_4 = 3'd4, ST_5 = 3'd5, ST_6 = 3'd6, ST_7 = 3'd7
  } step_t;

  step_t         step_q, step_nx;
  logic [PW-1:0] prescaler, prescaler_nx;
  logic          len_nx, sweep_nx, env_nx;
  logic          tick;

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler      <= '0;
      step_q         <= ST_0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_envelope   <= 1'b0;
    end else begin
      prescaler      <= prescaler_nx;
      step_q         <= step_nx;
      clk_length_ctr <= len_nx;
      clk_sweep      <= sweep_nx;
      clk_envelope   <= env_nx;
    end
  end

  // Priority: power-off, then DIV write (which swallows a coincident tick),
  // then normal counting.
  always_comb begin
    prescaler_nx = prescaler;
    step_nx      = step_q;
    len_nx       = 1'b0;
    sweep_nx     = 1'b0;
    env_nx       = 1'b0;
    if (!apu_enable) begin
      prescaler_nx = '0;
      step_nx      = ST_0;
    end else if (div_reset) begin
      prescaler_nx = '0;
    end else if (tick) begin
      prescaler_nx = '0;
      step_nx      = step_t'(step_q + 3'd1);
      unique case (step_q)
        ST_0, ST_4: len_nx = 1'b1;
        ST_2, ST_6: begin
          len_nx   = 1'b1;
          sweep_nx = 1'b1;
        end
        ST_7:       env_nx = 1'b1;
        default:    ;
      endcase
    end else begin
      prescaler_nx = prescaler + PW'(1);
    end
  end

  assign step        = step_q;
  assign length_next = ~step_q[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
module tb_gb_frame_sequencer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       apu_enable;
  logic       div_reset;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_envelope;
  logic [2:0] step;
  logic       length_next;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected strobe pattern per edge, {envelope, sweep, length}.
  logic [2:0] exp_q[$];
  logic [2:0] sched [8];

  gb_frame_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .apu_enable     (apu_enable),
    .div_reset      (div_reset),
    .clk_length_ctr (clk_length_ctr),
    .clk_sweep      (clk_sweep),
    .clk_envelope   (clk_envelope),
    .step           (step),
    .length_next    (length_next)
  );

  always #5 clk = ~clk;

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Power-cycle the APU for one edge: leaves prescaler=0, step=0.
  task automatic restart();
    @(negedge clk);
    apu_enable = 1'b0;
    @(negedge clk);
    apu_enable = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] exp, got;
    reset = 1'b0; apu_enable = 1'b0; div_reset = 1'b0;
    repeat (3) edge_sample();
    tests_run++;
    if ({clk_envelope, clk_sweep, clk_length_ctr, step, length_next} !== 7'b000_000_1) begin
      tests_failed++;
      $display("FAIL reset_outputs: got strobes=%b step=%0d length_next=%b, want 000/0/1",
               {clk_envelope, clk_sweep, clk_length_ctr}, step, length_next);
    end
    @(negedge clk);
    reset = 1'b1; apu_enable = 1'b1;
    exp_q.push_back(3'b000); exp_q.push_back(3'b000); exp_q.push_back(3'b000);
    exp_q.push_back(3'b001); exp_q.push_back(3'b000);
    for (int e = 1; e <= 5; e++) begin
      edge_sample();
      exp = exp_q.pop_front();
      got = {clk_envelope, clk_sweep, clk_length_ctr};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL power_on_edge%0d: got %b want %b", e, got, exp);
      end
      if (e == 4) begin
        tests_run++;
        if (step !== 3'd1) begin
          tests_failed++;
          $display("FAIL power_on_step: got %0d want 1", step);
        end
      end
    end
  endtask

  task automatic test_full_schedule();
    logic [2:0] exp, got;
    logic [2:0] exp_step;
    int n_len, n_sw, n_env;
    n_len = 0; n_sw = 0; n_env = 0; exp_step = 3'd0;
    restart();
    for (int k = 1; k <= 32; k++)
      exp_q.push_back((k % CLK_DIV == 0) ? sched[(k / CLK_DIV) - 1] : 3'b000);
    for (int k = 1; k <= 32; k++) begin
      edge_sample();
      if (k % CLK_DIV == 0) exp_step = exp_step + 3'd1;
      exp = exp_q.pop_front();
      got = {clk_envelope, clk_sweep, clk_length_ctr};
      n_len += int'(clk_length_ctr); n_sw += int'(clk_sweep); n_env += int'(clk_envelope);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL schedule_edge%0d: got %b want %b", k, got, exp);
      end
      tests_run++;
      if (step !== exp_step) begin
        tests_failed++;
        $display("FAIL schedule_step_edge%0d: got %0d want %0d", k, step, exp_step);
      end
      tests_run++;
      if (length_next !== ~exp_step[0]) begin
        tests_failed++;
        $display("FAIL length_next_step%0d: got %b want %b", exp_step, length_next, ~exp_step[0]);
      end
    end
    tests_run++;
    if (n_len != 4 || n_sw != 2 || n_env != 1) begin
      tests_failed++;
      $display("FAIL pulse_counts: got L=%0d S=%0d E=%0d want 4/2/1", n_len, n_sw, n_env);
    end
  endtask

  task automatic test_power_off();
    logic [2:0] exp, got;
    restart();
    repeat (22) edge_sample();
    tests_run++;
    if (step !== 3'd5) begin
      tests_failed++;
      $display("FAIL poweroff_setup_step: got %0d want 5", step);
    end
    @(negedge clk);
    apu_enable = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge_sample();
      tests_run++;
      if ({clk_envelope, clk_sweep, clk_length_ctr} !== 3'b000 || step !== 3'd0 ||
          dut.prescaler !== '0) begin
        tests_failed++;
        $display("FAIL poweroff_edge%0d: got strobes=%b step=%0d prescaler=%0d want 000/0/0",
                 e, {clk_envelope, clk_sweep, clk_length_ctr}, step, dut.prescaler);
      end
    end
    @(negedge clk);
    apu_enable = 1'b1;
    exp_q.push_back(3'b000); exp_q.push_back(3'b000);
    exp_q.push_back(3'b000); exp_q.push_back(3'b001);
    for (int e = 1; e <= 4; e++) begin
      edge_sample();
      exp = exp_q.pop_front();
      got = {clk_envelope, clk_sweep, clk_length_ctr};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reenable_edge%0d: got %b want %b", e, got, exp);
      end
    end
  endtask

  task automatic test_div_reset();
    logic [2:0] exp, got;
    restart();
    repeat (3) edge_sample();
    @(negedge clk);
    div_reset = 1'b1;
    edge_sample();
    tests_run++;
    if ({clk_envelope, clk_sweep, clk_length_ctr} !== 3'b000 || step !== 3'd0 ||
        dut.prescaler !== '0) begin
      tests_failed++;
      $display("FAIL div_suppress: got strobes=%b step=%0d prescaler=%0d want 000/0/0",
               {clk_envelope, clk_sweep, clk_length_ctr}, step, dut.prescaler);
    end
    @(negedge clk);
    div_reset = 1'b0;
    exp_q.push_back(3'b000); exp_q.push_back(3'b000);
    exp_q.push_back(3'b000); exp_q.push_back(3'b001);
    for (int e = 1; e <= 4; e++) begin
      edge_sample();
      exp = exp_q.pop_front();
      got = {clk_envelope, clk_sweep, clk_length_ctr};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL div_after_edge%0d: got %b want %b", e, got, exp);
      end
    end
    tests_run++;
    if (step !== 3'd1) begin
      tests_failed++;
      $display("FAIL div_after_step: got %0d want 1", step);
    end
  endtask

  task automatic test_async_reset();
    restart();
    repeat (4) edge_sample();
    tests_run++;
    if (clk_length_ctr !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_setup_strobe: got %b want 1", clk_length_ctr);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (clk_length_ctr !== 1'b0 || step !== 3'd0 || length_next !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: got len=%b step=%0d length_next=%b want 0/0/1",
               clk_length_ctr, step, length_next);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    sched[0] = 3'b001; sched[1] = 3'b000; sched[2] = 3'b011; sched[3] = 3'b000;
    sched[4] = 3'b001; sched[5] = 3'b000; sched[6] = 3'b011; sched[7] = 3'b100;
    test_reset();
    test_full_schedule();
    test_power_off();
    test_div_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
